load_unit: RTL and testbench
============================

LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 Parameter TIMEOUT, default 15, SHALL set the maximum number of REQ-state cycles waiting for mem_ready (legal range 1..255).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  load request, sampled only in IDLE.
REQ-005 funct3  input  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; all other codes illegal.
REQ-006 addr  input  32  byte address of the load.
REQ-007 mem_req  output  1  memory read request, held high until accepted.
REQ-008 mem_addr  output  32  word address {addr[31:2],2'b00}, stable while mem_req is high.
REQ-009 mem_ready  input  1  memory ack; mem_rdata valid in the same cycle.
REQ-010 mem_rdata  input  32  little-endian read word.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 rdata  output  32  extended load result, valid when done=1.
REQ-014 err  output  1  qualifies done: the load failed.
REQ-015 err_code  output  2  00 none, 01 misaligned, 10 illegal funct3, 11 timeout.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, REQ, DONE.
REQ-017 In IDLE with start=1, funct3, addr[1:0] and the access type SHALL be captured into internal registers; later input changes SHALL have no effect until the next IDLE.
REQ-018 An illegal funct3 SHALL go IDLE->DONE with err=1 and err_code=10; mem_req SHALL never rise.
REQ-019 A misaligned access (lh/lhu with addr[0]=1, lw with addr[1:0]!=00) SHALL go IDLE->DONE with err=1 and err_code=01; mem_req SHALL never rise.
REQ-020 An illegal funct3 SHALL take priority over misalignment.
REQ-021 A legal, aligned access SHALL go IDLE->REQ, with mem_req=1 in the cycle after start.
REQ-022 In REQ, a cycle with mem_ready=1 SHALL capture mem_rdata and go to DONE.
REQ-023 A 8-bit wait counter SHALL clear on REQ entry and increment each REQ cycle with mem_ready=0.
REQ-024 When the counter reaches TIMEOUT with mem_ready=0, the FSM SHALL go to DONE with err=1, err_code=11 and rdata=0.
REQ-025 mem_ready=1 in the same cycle the counter reaches TIMEOUT SHALL count as success.
REQ-026 DONE SHALL last exactly one cycle with done=1, then return to IDLE; start in DONE SHALL be ignored.
REQ-027 Byte lane: lb/lbu SHALL select mem_rdata[8*addr[1:0]+7 : 8*addr[1:0]]; lh/lhu SHALL select bits [15:0] when addr[1]=0 and [31:16] when addr[1]=1; lw SHALL pass the full word.
REQ-028 lb/lh SHALL sign-extend the selected field to 32 bits (replicate its MSB); lbu/lhu SHALL zero-extend it.
REQ-029 rdata SHALL be 0 whenever err=1.
REQ-030 rdata SHALL hold its last value while done=0.
REQ-031 mem_ready outside REQ SHALL be ignored.
REQ-032 Latency: a successful load SHALL raise done exactly one cycle after the accepting mem_ready; an error load SHALL raise done in the cycle after start.
REQ-033 Minimum throughput: one load per 3 cycles (start, REQ with immediate ready, DONE).

Reset
REQ-034 With reset=1 at a rising edge, the FSM SHALL enter IDLE regardless of state, including mid-REQ.
REQ-035 In the cycle after reset, outputs SHALL be mem_req=0, mem_addr=0, busy=0, done=0, rdata=0, err=0, err_code=00, and the wait counter SHALL be 0.
REQ-036 A memory response pending across reset SHALL be dropped; no done pulse SHALL result from it.

Verification
REQ-037 lb, addr=0x1003, mem_rdata=0x80FF1234, ready on first REQ cycle -> done one cycle after ready, rdata=0xFFFFFF80, err=0.
REQ-038 lhu, addr=0x2002, mem_rdata=0x8001ABCD, ready after 3 wait cycles -> mem_addr=0x2000, rdata=0x00008001.
REQ-039 lw, addr=0x0006 -> done=1, err=1, err_code=01 in cycle after start, mem_req never high; funct3=011 -> err_code=10.
REQ-040 lw, TIMEOUT=4, mem_ready held 0 -> done with err_code=11 after 4 REQ cycles; repeat with ready on the 4th cycle -> success.
REQ-041 Reset asserted during REQ, then mem_ready=1 -> no done pulse, busy=0, all outputs at reset values.
REQ-042 Back-to-back lb/lbu to addr=0x3001, mem_rdata=0x0000F000, start held high -> rdata 0xFFFFFFF0 then 0x000000F0, second load accepted only after DONE.

Source files
------------

// File: rtl/load_unit.sv
// Load unit: sequences a single memory read per request, checks alignment and
// funct3 legality, bounds the memory wait, and returns the lane-selected, extended result.
module load_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic [1:0]  err_code
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [1:0]  code_q, code_d;

    function automatic logic is_illegal(input logic [2:0] f3);
        return !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                 f3 == 3'b100 || f3 == 3'b101);
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic m;
        case (f3[1:0])
            2'b01:   m = off[0];
            2'b10:   m = (off != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] extend_load(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] w);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        b = $signed(8'(w >> {off, 3'b000}));
        h = off[1] ? $signed(w[31:16]) : $signed(w[15:0]);
        case (f3)
            3'b000:  r = 32'(b);
            3'b100:  r = {24'b0, b};
            3'b001:  r = 32'(h);
            3'b101:  r = {16'b0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    f3_d   = funct3;
                    addr_d = addr;
                    cnt_d  = 8'd0;
                    if (is_illegal(funct3)) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        code_d  = 2'b10;
                        rdata_d = 32'd0;
                    end else if (is_misaligned(funct3, addr[1:0])) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        code_d  = 2'b01;
                        rdata_d = 32'd0;
                    end else begin
                        state_d = REQ;
                        err_d   = 1'b0;
                        code_d  = 2'b00;
                    end
                end
            end
            REQ: begin
                // A response arriving on the final allowed cycle still wins over the timeout.
                if (mem_ready) begin
                    state_d = DONE;
                    rdata_d = extend_load(f3_q, addr_q[1:0], mem_rdata);
                    err_d   = 1'b0;
                    code_d  = 2'b00;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == TIMEOUT_C) begin
                        state_d = DONE;
                        rdata_d = 32'd0;
                        err_d   = 1'b1;
                        code_d  = 2'b11;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            f3_q    <= 3'b000;
            addr_q  <= 32'd0;
            cnt_q   <= 8'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign mem_req  = (state_q == REQ);
    assign mem_addr = {addr_q[31:2], 2'b00};
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign rdata    = rdata_q;
    assign err      = done && err_q;
    assign err_code = done ? code_q : 2'b00;

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: a transaction-level reference predicts every
// output on every cycle, and a few literal results pin the reference itself.
module tb_load_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  err_code;

    load_unit #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .funct3    (funct3),
        .addr      (addr),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic        chk_en = 1'b0;
    logic        exp_busy, exp_done, exp_err, exp_mreq, exp_maddr_en;
    logic [1:0]  exp_code;
    logic [31:0] exp_rdata, exp_maddr, last_rdata;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("busy",     32'(busy),     32'(exp_busy));
            cmp("done",     32'(done),     32'(exp_done));
            cmp("err",      32'(err),      32'(exp_err));
            cmp("err_code", 32'(err_code), 32'(exp_code));
            cmp("rdata",    rdata,         exp_rdata);
            cmp("mem_req",  32'(mem_req),  32'(exp_mreq));
            if (exp_maddr_en) cmp("mem_addr", mem_addr, exp_maddr);
        end
    end

    // Reference result: shift the word down to the selected field, mask it,
    // and for signed loads map values past the midpoint to their negative.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
        longint unsigned v;
        int width;
        int sh;
        case (f3)
            3'b000, 3'b100: begin width = 8;  sh = 8 * int'(a[1:0]); end
            3'b001, 3'b101: begin width = 16; sh = 16 * int'(a[1]);  end
            default:        begin width = 32; sh = 0;                end
        endcase
        v = (64'(w) >> sh) % (64'd1 << width);
        if ((f3 == 3'b000 || f3 == 3'b001) && v >= (64'd1 << (width - 1)))
            v = v + (64'd1 << 32) - (64'd1 << width);
        return v[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_idle();
        exp_busy     = 1'b0;
        exp_done     = 1'b0;
        exp_err      = 1'b0;
        exp_code     = 2'b00;
        exp_mreq     = 1'b0;
        exp_maddr_en = 1'b0;
        exp_rdata    = last_rdata;
    endtask

    task automatic expect_reset();
        expect_idle();
        exp_rdata    = 32'd0;
        last_rdata   = 32'd0;
        exp_maddr_en = 1'b1;
        exp_maddr    = 32'd0;
    endtask

    // wait_n: REQ cycles with mem_ready low before the ready cycle (>= TO means never ready).
    task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w,
                           input int wait_n, input logic hold,
                           input logic lit_en, input logic [31:0] lit, input logic [1:0] lit_code);
        logic        illegal;
        logic        mis;
        logic [1:0]  code;
        logic [31:0] res;
        illegal = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        mis = (f3 == 3'b001 || f3 == 3'b101) ? a[0] :
              (f3 == 3'b010) ? (a[1:0] != 2'b00) : 1'b0;
        start     = 1'b1;
        funct3    = f3;
        addr      = a;
        mem_ready = 1'b0;
        tick();
        if (!hold) start = 1'b0;
        funct3 = 3'b010;
        addr   = ~a;
        if (illegal || mis) begin
            code = illegal ? 2'b10 : 2'b01;
            res  = 32'd0;
        end else begin
            exp_busy     = 1'b1;
            exp_done     = 1'b0;
            exp_err      = 1'b0;
            exp_code     = 2'b00;
            exp_mreq     = 1'b1;
            exp_maddr_en = 1'b1;
            exp_maddr    = {a[31:2], 2'b00};
            exp_rdata    = last_rdata;
            for (int k = 0; k < TO; k++) begin
                mem_ready = (k == wait_n);
                mem_rdata = (k == wait_n) ? w : (32'hDEAD_0000 ^ 32'(k));
                tick();
                if (k == wait_n) break;
            end
            code = (wait_n < TO) ? 2'b00 : 2'b11;
            res  = (wait_n < TO) ? ref_load(f3, a, w) : 32'd0;
        end
        exp_busy     = 1'b1;
        exp_done     = 1'b1;
        exp_err      = (code != 2'b00);
        exp_code     = code;
        exp_rdata    = res;
        exp_mreq     = 1'b0;
        exp_maddr_en = 1'b0;
        last_rdata   = res;
        mem_ready    = 1'b1;
        mem_rdata    = 32'h1234_5678;
        if (lit_en) begin
            cmp("lit_rdata", rdata, lit);
            cmp("lit_code",  32'(err_code), 32'(lit_code));
        end
        tick();
        mem_ready = 1'b0;
        expect_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        funct3    = 3'b000;
        addr      = 32'd0;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        tick();
        expect_reset();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // lb sign-extended top byte, ready on first REQ cycle
        do_load(3'b000, 32'h0000_1003, 32'h80FF_1234, 0, 1'b0, 1'b1, 32'hFFFF_FF80, 2'b00);
        // lhu upper half, ready on the last cycle before timeout
        do_load(3'b101, 32'h0000_2002, 32'h8001_ABCD, 3, 1'b0, 1'b1, 32'h0000_8001, 2'b00);
        // misaligned word, illegal funct3, illegal beats misaligned
        do_load(3'b010, 32'h0000_0006, 32'hFFFF_FFFF, 0, 1'b0, 1'b1, 32'h0000_0000, 2'b01);
        do_load(3'b011, 32'h0000_0000, 32'hFFFF_FFFF, 0, 1'b0, 1'b1, 32'h0000_0000, 2'b10);
        do_load(3'b111, 32'h0000_0003, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 32'h0, 2'b00);
        do_load(3'b001, 32'h0000_0011, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 32'h0, 2'b00);
        // other lanes and widths
        do_load(3'b001, 32'h0000_0102, 32'hF00D_1234, 1, 1'b0, 1'b1, 32'hFFFF_F00D, 2'b00);
        do_load(3'b001, 32'h0000_0100, 32'hF00D_1234, 2, 1'b0, 1'b0, 32'h0, 2'b00);
        do_load(3'b010, 32'hABCD_0008, 32'hCAFE_BABE, 0, 1'b0, 1'b1, 32'hCAFE_BABE, 2'b00);
        do_load(3'b100, 32'h0000_0002, 32'h00A5_0000, 0, 1'b0, 1'b1, 32'h0000_00A5, 2'b00);

        // reset in the middle of REQ with a response arriving alongside
        start  = 1'b1;
        funct3 = 3'b010;
        addr   = 32'h0000_0100;
        tick();
        start        = 1'b0;
        exp_busy     = 1'b1;
        exp_mreq     = 1'b1;
        exp_maddr_en = 1'b1;
        exp_maddr    = 32'h0000_0100;
        tick();
        reset     = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'h7777_7777;
        tick();
        expect_reset();
        reset = 1'b0;
        tick();
        expect_idle();
        mem_ready = 1'b0;
        tick();

        // timeout after TO REQ cycles, then success on the final cycle
        do_load(3'b010, 32'h0000_0040, 32'h1111_2222, TO, 1'b0, 1'b1, 32'h0000_0000, 2'b11);
        do_load(3'b010, 32'h0000_0040, 32'h1111_2222, TO - 1, 1'b0, 1'b1, 32'h1111_2222, 2'b00);

        // back-to-back with start held high
        do_load(3'b000, 32'h0000_3001, 32'h0000_F000, 0, 1'b1, 1'b1, 32'hFFFF_FFF0, 2'b00);
        do_load(3'b100, 32'h0000_3001, 32'h0000_F000, 0, 1'b1, 1'b1, 32'h0000_00F0, 2'b00);
        start = 1'b0;
        tick();
        tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
